// File: rtl/sync_fifo_pkg.sv
// Shared types and default widths for the FIFO stream reader.
package sync_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LEN_WIDTH_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/sync_fifo_skid_buf.sv
// Two-entry FIFO-ordered output buffer; the head entry register drives the stream outputs directly.
module sync_fifo_skid_buf #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] dout_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push_ok, pop_ok;

  assign push_ok = push_i & (cnt_q != 2'd2);
  assign pop_ok  = pop_i & (cnt_q != 2'd0);

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case ({push_ok, pop_ok})
      2'b10: begin
        if (cnt_q == 2'd0) head_d = din_i;
        else               tail_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // With one entry left the head is simply invalidated and holds its value.
        if (cnt_q == 2'd2) head_d = tail_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign dout_o  = head_q;

endmodule

// File: rtl/sync_fifo_stream_reader.sv
// Reads fixed-length frames from a FIFO read port and presents them as a valid/ready stream.
module sync_fifo_stream_reader
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LEN_WIDTH  = LEN_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  output logic                  fifo_ren,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  input  logic                  fifo_rempty,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  rd_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic [15:0]          frame_count_q, frame_count_d;
  logic [1:0]           buf_count;
  logic [DATA_WIDTH:0]  buf_head;
  logic                 is_last;
  logic                 hs;

  assign is_last  = (beat_cnt_q == len_q);
  // Reads continue past a dropped enable until the current frame is complete.
  assign fifo_ren = ~reset & (state_q == RUN) & ~fifo_rempty & (buf_count < 2'd2) &
                    (enable | (beat_cnt_q != '0));
  assign hs       = m_valid & m_ready;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d    = RUN;
          len_d      = burst_len;
          beat_cnt_d = '0;
        end
      end
      RUN: begin
        if (fifo_ren) begin
          if (is_last) begin
            beat_cnt_d = '0;
            len_d      = burst_len;
          end else begin
            beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
          end
        end
        if (!enable && (beat_cnt_d == '0)) state_d = DRAIN;
      end
      DRAIN: begin
        if (buf_count == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (hs && m_last) frame_count_d = frame_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  sync_fifo_skid_buf #(
    .W(DATA_WIDTH + 1)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_ren),
    .din_i  ({is_last, fifo_rdata}),
    .pop_i  (m_ready),
    .count_o(buf_count),
    .dout_o (buf_head)
  );

  assign m_valid     = (buf_count != 2'd0);
  assign m_data      = buf_head[DATA_WIDTH-1:0];
  assign m_last      = buf_head[DATA_WIDTH];
  assign busy        = (state_q != IDLE);
  assign frame_count = frame_count_q;

endmodule
